image_write_ctrl: RTL

IMAGE_WRITE_CTRL -- requirements
Module: image_write_ctrl

---
 rtl/image_write_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/image_write_ctrl.sv
// Image write controller: accepts pixel pairs from an upstream source while a frame
// is running, walks a column/row position across a WIDTH x HEIGHT image (two pixels
// per transfer), and presents each accepted pair one cycle later with its position.
//
// Ports:
//   HCLK, HRESETn      clock, asynchronous active-low reset
//   start, abort       frame start request (IDLE only) / synchronous frame cancel
//   in_valid, in_ready upstream handshake; in_data = {R0,G0,B0,R1,G1,B1}
//   out_hsync          strobe: out_data/out_col/out_row are valid this cycle
//   out_data           registered copy of the accepted pair
//   out_col, out_row   pair index within the row, row index (zero-extended)
//   busy, frame_done   not-IDLE flag, single-cycle end-of-frame pulse
module image_write_ctrl #(
    parameter int unsigned WIDTH    = 768,
    parameter int unsigned HEIGHT   = 512,
    parameter int unsigned LINE_GAP = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_hsync,
    output logic [47:0] out_data,
    output logic [15:0] out_col,
    output logic [15:0] out_row,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned ColLast = WIDTH / 2 - 1;
    localparam int unsigned RowLast = HEIGHT - 1;
    localparam int unsigned GapLast = (LINE_GAP > 0) ? LINE_GAP - 1 : 0;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StGap,
        StFlush,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    logic [15:0] gap_q, gap_d;
    logic        xfer;

    assign in_ready   = (state_q == StRun);
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);

    // A handshake that coincides with abort is dropped entirely.
    assign xfer = in_ready && in_valid && !abort;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        gap_d   = gap_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    col_d   = '0;
                    row_d   = '0;
                    gap_d   = '0;
                end
            end
            StRun: begin
                if (xfer) begin
                    if (col_q == 16'(ColLast)) begin
                        col_d = '0;
                        if (row_q == 16'(RowLast)) begin
                            state_d = StFlush;
                        end else begin
                            row_d = row_q + 16'd1;
                            if (LINE_GAP != 0) begin
                                state_d = StGap;
                                gap_d   = '0;
                            end
                        end
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            StGap: begin
                if (gap_q == 16'(GapLast)) begin
                    state_d = StRun;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            StFlush: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // abort overrides everything, including start and a pending transfer
        if (abort) begin
            state_d = StIdle;
            col_d   = '0;
            row_d   = '0;
            gap_d   = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            gap_q   <= gap_d;
        end
    end

    // Output register: captures the pair and its position; holds while idle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            out_hsync <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_row   <= '0;
        end else begin
            out_hsync <= xfer;
            if (xfer) begin
                out_data <= in_data;
                out_col  <= col_q;
                out_row  <= row_q;
            end
        end
    end

endmodule
